// File: rtl/ifetch_queue.sv
// ifetch_queue
// Instruction-fetch stage that sits directly after the program counter.
// It owns the fetch PC, issues in-order word reads to instruction memory,
// buffers the returned instructions in a small FIFO and hands them to decode.
// A branch redirect flushes the queue, turns every outstanding request into
// a stale one whose response gets dropped, and restarts fetch at the new PC.
//
// Optional feature macro: IFETCH_BYPASS_EN
//   Defined   - when the queue is empty, a live response with no redirect that
//               cycle is driven straight onto inst_* in the same cycle. If decode
//               is ready it is consumed and never written into the queue.
//   Undefined - every response goes through the queue, so it reaches inst_*
//               one cycle after it arrives and inst_* come only from registers
//               (apart from being forced to zero during reset).
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word address of the request (the fetch PC)
//   imem_resp_valid  response valid; responses come back in request order
//   imem_resp_data   instruction word of the response
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      new fetch PC
//   inst_valid       queue head valid
//   inst_ready       decode consumes the head this cycle
//   inst_data        head instruction
//   inst_pc          address of the head instruction

module ifetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

    // FETCH while no stale responses are pending, DRAIN while some are.
    typedef enum logic {FETCH, DRAIN} FetchState;

    FetchState         stateQ, stateD;
    logic [ADDR_W-1:0] fetchPcQ, fetchPcD;
    logic [CW-1:0]     liveQ, liveD;
    logic [CW-1:0]     staleQ, staleD;
    logic [CW-1:0]     countQ, countD;
    logic [PW-1:0]     qHeadQ, qHeadD;
    logic [PW-1:0]     qTailQ, qTailD;
    logic [PW-1:0]     pcWrQ, pcWrD;
    logic [PW-1:0]     pcRdQ, pcRdD;

    logic [DATA_W-1:0] dataMem  [DEPTH];
    logic [ADDR_W-1:0] pcMem    [DEPTH];
    logic [ADDR_W-1:0] reqPcMem [DEPTH];

    logic              reqFire;
    logic              respStale;
    logic              respLive;
    logic              headValid;
    logic              bypassHit;
    logic              bypassTaken;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] respPc;

    // The PC FIFO holds the address of every outstanding request, live or
    // stale, so it is popped on every response. live+stale never exceeds
    // DEPTH, so it can never overflow.
    assign respPc    = reqPcMem[pcRdQ];
    assign headValid = (countQ != '0);

    // Stop requesting when the queue could not absorb every live response,
    // or when the number of outstanding requests reaches DEPTH.
    assign imem_req_valid = !rst && !redirect_valid
                            && (({1'b0, countQ} + {1'b0, liveQ}) < DEPTH_S)
                            && (({1'b0, liveQ} + {1'b0, staleQ}) < DEPTH_S);
    assign imem_req_addr  = fetchPcQ;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign respStale = imem_resp_valid && (staleQ != '0);
    assign respLive  = imem_resp_valid && (staleQ == '0);

`ifdef IFETCH_BYPASS_EN
    assign bypassHit = !headValid && respLive && !redirect_valid;
`else
    assign bypassHit = 1'b0;
`endif

    assign bypassTaken = bypassHit && inst_ready;
    assign push        = respLive && !redirect_valid && !bypassTaken;
    assign pop         = headValid && inst_ready && !redirect_valid;

    // Decode-facing outputs: the queue head if there is one, otherwise the
    // bypassed response (only possible when the bypass is built in).
    always_comb begin
        inst_valid = 1'b0;
        inst_data  = '0;
        inst_pc    = '0;
        if (!rst) begin
            if (headValid) begin
                inst_valid = 1'b1;
                inst_data  = dataMem[qHeadQ];
                inst_pc    = pcMem[qHeadQ];
            end else if (bypassHit) begin
                inst_valid = 1'b1;
                inst_data  = imem_resp_data;
                inst_pc    = respPc;
            end
        end
    end

    // Next-state logic. A redirect wipes the queue and moves all live
    // requests into stale; a live response arriving in the redirect cycle
    // has its request already counted in live, so one is taken back off.
    always_comb begin
        fetchPcD = fetchPcQ;
        liveD    = liveQ;
        staleD   = staleQ;
        countD   = countQ;
        qHeadD   = qHeadQ;
        qTailD   = qTailQ;
        pcWrD    = pcWrQ;
        pcRdD    = pcRdQ;

        if (reqFire) begin
            fetchPcD = fetchPcQ + ADDR_W'(1);
            pcWrD    = pcWrQ + PW'(1);
        end
        if (imem_resp_valid) begin
            pcRdD = pcRdQ + PW'(1);
        end

        if (redirect_valid) begin
            fetchPcD = redirect_pc;
            liveD    = '0;
            staleD   = staleQ + liveQ - CW'(imem_resp_valid);
            countD   = '0;
            qHeadD   = '0;
            qTailD   = '0;
        end else begin
            liveD  = liveQ + CW'(reqFire) - CW'(respLive);
            staleD = staleQ - CW'(respStale);
            if (push) begin
                qTailD = qTailQ + PW'(1);
            end
            if (pop) begin
                qHeadD = qHeadQ + PW'(1);
            end
            countD = countQ + CW'(push) - CW'(pop);
        end

        stateD = (staleD != '0) ? DRAIN : FETCH;
    end

    // Control registers and the FETCH/DRAIN state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= FETCH;
            fetchPcQ <= RESET_PC;
            liveQ    <= '0;
            staleQ   <= '0;
            countQ   <= '0;
            qHeadQ   <= '0;
            qTailQ   <= '0;
            pcWrQ    <= '0;
            pcRdQ    <= '0;
        end else begin
            stateQ   <= stateD;
            fetchPcQ <= fetchPcD;
            liveQ    <= liveD;
            staleQ   <= staleD;
            countQ   <= countD;
            qHeadQ   <= qHeadD;
            qTailQ   <= qTailD;
            pcWrQ    <= pcWrD;
            pcRdQ    <= pcRdD;
        end
    end

    // Storage arrays carry no reset; the pointers and counters decide which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (reqFire) begin
            reqPcMem[pcWrQ] <= fetchPcQ;
        end
        if (push) begin
            dataMem[qTailQ] <= imem_resp_data;
            pcMem[qTailQ]   <= respPc;
        end
    end

    // A response with nothing outstanding is a memory protocol error.
    assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((liveQ != '0) || (staleQ != '0)));

    // The debug state must agree with the stale counter.
    assert property (@(posedge clk) disable iff (rst)
        (stateQ == DRAIN) == (staleQ != '0));

    // Counters stay within their bounds.
    assert property (@(posedge clk) disable iff (rst)
        (({1'b0, liveQ} + {1'b0, staleQ}) <= DEPTH_S) && ({1'b0, countQ} <= DEPTH_S));

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue
// Directed and randomized bench for ifetch_queue. A memory model returns
// in-order responses (data = address + 0x100) with configurable latency.
// The reference model works at the level of the instruction stream: after
// reset or a redirect to P, fetch addresses must run P, P+1, ... and decode
// must see exactly that sequence with the matching data, nothing older.

module tb_ifetch_queue;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

`ifdef IFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } MemReq;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid = 1'b0;
    logic [DATA_W-1:0] imem_resp_data = '0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    MemReq             memQ[$];
    logic [ADDR_W-1:0] consLog[$];
    int                passCount = 0;
    int                failCount = 0;
    int                checkCount = 0;
    int                cycleNum = 0;
    int                consumedCount = 0;
    int                latMin = 1;
    int                latMax = 1;
    logic [ADDR_W-1:0] expPc = RESET_PC;
    logic [ADDR_W-1:0] expFetch = RESET_PC;
    logic              lastReqValid;
    logic [ADDR_W-1:0] lastReqAddr;
    logic              lastInstValid;
    logic [ADDR_W-1:0] lastInstPc;

    ifetch_queue #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence itself ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_W-1:0] memData(input logic [ADDR_W-1:0] a);
        return 16'h0100 + {8'h00, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, let the DUT
    // settle, check against the model, then advance past the rising edge.
    task automatic applyStimulus(input bit rstV, input bit readyV, input bit instReadyV,
                                 input bit redirV, input logic [ADDR_W-1:0] redirPcV,
                                 input bit respEn);
        bit respGiven;
        MemReq r;
        @(negedge clk);
        rst            = rstV;
        imem_req_ready = readyV;
        inst_ready     = instReadyV;
        redirect_valid = redirV;
        redirect_pc    = redirPcV;
        respGiven      = !rstV && respEn && (memQ.size() > 0) && (memQ[0].due <= cycleNum);
        imem_resp_valid = respGiven;
        imem_resp_data  = respGiven ? memData(memQ[0].addr) : DATA_W'($urandom);
        #1;
        lastReqValid  = imem_req_valid;
        lastReqAddr   = imem_req_addr;
        lastInstValid = inst_valid;
        lastInstPc    = inst_pc;

        if (rstV) begin
            checkOutput("rstReqValid", 32'(imem_req_valid), 0);
            checkOutput("rstInstValid", 32'(inst_valid), 0);
            checkOutput("rstInstData", 32'(inst_data), 0);
            checkOutput("rstInstPc", 32'(inst_pc), 0);
            memQ.delete();
            expPc    = RESET_PC;
            expFetch = RESET_PC;
        end else begin
            if (redirV) begin
                checkOutput("redirNoReq", 32'(imem_req_valid), 0);
            end
            if (imem_req_valid && readyV) begin
                checkOutput("reqAddr", 32'(imem_req_addr), 32'(expFetch));
                checkOutput("outstanding", 32'(memQ.size() < DEPTH), 1);
                r.addr = imem_req_addr;
                r.due  = cycleNum + int'($urandom_range(latMax, latMin));
                memQ.push_back(r);
                expFetch = expFetch + 8'd1;
            end
            if (inst_valid && instReadyV && !redirV) begin
                checkOutput("instPc", 32'(inst_pc), 32'(expPc));
                checkOutput("instData", 32'(inst_data), 32'(memData(expPc)));
                consLog.push_back(inst_pc);
                consumedCount++;
                expPc = expPc + 8'd1;
            end
            if (redirV) begin
                expPc    = redirPcV;
                expFetch = redirPcV;
            end
            if (respGiven) begin
                void'(memQ.pop_front());
            end
        end
        @(posedge clk);
        cycleNum++;
    endtask

    initial begin
        bit found;
        int firstIdx;
        int startCount;
        logic [ADDR_W-1:0] firstPc;
        logic [ADDR_W-1:0] foundAddr;
        bit ready, iready, redir, rstR, respEn;

        // Reset held three cycles.
        repeat (3) applyStimulus(1, 1, 1, 0, 8'h00, 1);

        // Streaming, one instruction per cycle once the pipeline fills.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 1);
            if (k == 0) begin
                checkOutput("firstReqAddr", 32'(lastReqAddr), 0);
            end
            checkOutput("streamReq", 32'(lastReqValid), 1);
            if (k >= (BYPASS ? 1 : 2)) begin
                checkOutput("streamValid", 32'(lastInstValid), 1);
                checkOutput("streamPc", 32'(lastInstPc), 32'(k - (BYPASS ? 1 : 2)));
            end
        end

        // Backpressure: queue fills with 4 entries and fetch stops.
        applyStimulus(1, 1, 1, 0, 8'h00, 1);
        repeat (6) applyStimulus(0, 1, 0, 0, 8'h00, 1);
        checkOutput("bpReqStopped", 32'(lastReqValid), 0);
        checkOutput("bpHeadValid", 32'(lastInstValid), 1);
        checkOutput("bpHeadPc", 32'(lastInstPc), 0);
        consLog.delete();
        found = 0;
        foundAddr = '0;
        for (int k = 0; k < 10 && !found; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 1);
            if (lastReqValid) begin
                found = 1;
                foundAddr = lastReqAddr;
            end
        end
        checkOutput("bpResumed", 32'(found), 1);
        checkOutput("bpResumeAddr", 32'(foundAddr), 4);
        repeat (4) applyStimulus(0, 1, 1, 0, 8'h00, 1);
        checkOutput("bpDrainCount", 32'(consLog.size() >= 4), 1);
        if (consLog.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("bpDrainOrder", 32'(consLog[i]), 32'(i));
            end
        end

        // Redirect with two requests in flight at latency 3.
        latMin = 3;
        latMax = 3;
        applyStimulus(1, 1, 1, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 0, 8'h00, 1);
        checkOutput("rdInFlight", 32'(memQ.size()), 2);
        applyStimulus(0, 1, 1, 1, 8'h40, 1);
        found = 0;
        firstIdx = -1;
        firstPc = '0;
        for (int k = 0; k < 15 && !found; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 1);
            if (lastInstValid) begin
                found = 1;
                firstIdx = k;
                firstPc = lastInstPc;
            end
        end
        checkOutput("rdArrived", 32'(found), 1);
        checkOutput("rdFirstPc", 32'(firstPc), 32'h40);
        checkOutput("rdFirstCycle", 32'(firstIdx), BYPASS ? 3 : 4);

        // Wrap through the top of the address space.
        latMin = 1;
        latMax = 1;
        applyStimulus(0, 1, 1, 1, 8'hFE, 1);
        consLog.delete();
        repeat (8) applyStimulus(0, 1, 1, 0, 8'h00, 1);
        checkOutput("wrapCount", 32'(consLog.size() >= 3), 1);
        if (consLog.size() >= 3) begin
            checkOutput("wrapPc0", 32'(consLog[0]), 32'hFE);
            checkOutput("wrapPc1", 32'(consLog[1]), 32'hFF);
            checkOutput("wrapPc2", 32'(consLog[2]), 32'h00);
        end

        // Reset mid-stream.
        applyStimulus(1, 1, 1, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 0, 8'h00, 1);
        checkOutput("midRstEmpty", 32'(lastInstValid), 0);
        checkOutput("midRstReq", 32'(lastReqValid), 1);
        checkOutput("midRstAddr", 32'(lastReqAddr), 32'(RESET_PC));

        // Empty queue, response for address 5 with decode ready.
        applyStimulus(1, 1, 1, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 1, 8'h05, 1);
        applyStimulus(0, 1, 1, 0, 8'h00, 1);
        applyStimulus(0, 0, 1, 0, 8'h00, 1);
        checkOutput("bypSameCycle", 32'(lastInstValid), 32'(BYPASS));
        if (BYPASS) begin
            checkOutput("bypSamePc", 32'(lastInstPc), 5);
        end
        applyStimulus(0, 0, 1, 0, 8'h00, 1);
        checkOutput("bypNextCycle", 32'(lastInstValid), 32'(!BYPASS));
        if (!BYPASS) begin
            checkOutput("bypNextPc", 32'(lastInstPc), 5);
        end

        // Randomized traffic checked by the stream model.
        latMin = 1;
        latMax = 4;
        for (int k = 0; k < 2000; k++) begin
            rstR   = ($urandom_range(199, 0) == 0);
            redir  = !rstR && ($urandom_range(19, 0) == 0);
            ready  = ($urandom_range(3, 0) != 0);
            iready = ($urandom_range(3, 0) != 0);
            respEn = ($urandom_range(4, 0) != 0);
            applyStimulus(rstR, ready, iready, redir, ADDR_W'($urandom), respEn);
        end

        // Liveness: with everything ready the stream must keep flowing.
        latMin = 1;
        latMax = 1;
        startCount = consumedCount;
        repeat (40) applyStimulus(0, 1, 1, 0, 8'h00, 1);
        checkOutput("liveness", 32'((consumedCount - startCount) >= 20), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Owns the fetch PC register and issues in-order word reads to instruction memory over a valid/ready request channel.
- Buffers the returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports branch redirect: queued and in-flight instructions are flushed, and fetch restarts at a new PC.

Parameters:
- ADDR_W, 8, fetch address width (word addressed).
- DATA_W, 16, instruction width.
- DEPTH, 4, queue entries and maximum in-flight requests; power of 2, minimum 2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  ADDR_W  word address of the request.
- imem_resp_valid  input  1  response data valid; responses return in request order, latency ≥1 cycle.
- imem_resp_data  input  DATA_W  instruction word.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  ADDR_W  new fetch PC.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  DATA_W  head instruction.
- inst_pc  output  ADDR_W  address of the head instruction.

Behaviour:
- Reset: fetch_pc=RESET_PC; queue empty; live=0; stale=0.
  - While rst=1: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - rst mid-operation discards everything, including outstanding responses. The bench must not return pre-reset responses after reset.
- Counters:
  - live = accepted requests whose responses are still wanted.
  - stale = accepted requests whose responses must be discarded.
  - count = queue occupancy.
- Request rule: imem_req_valid = !rst && !redirect_valid && (count+live < DEPTH) && (live+stale < DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W; live += 1.
- Response rule:
  - If stale > 0: the response is discarded and stale -= 1.
  - Otherwise: push {data, pc} into the queue and live -= 1. The entry's pc comes from a parallel PC FIFO written at request acceptance.
  - A response with live=0 and stale=0 is a protocol error. Flag it with an assertion; no RTL recovery is required.
- Output: inst_valid = (count > 0). The head is popped when inst_valid && inst_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
  - With a full queue, pop and push in the same cycle are legal.
- Latency: a response accepted in cycle N appears on inst_* in cycle N+1.
- Redirect, cycle R:
  - The queue is cleared, and any pop in that cycle is ignored.
  - fetch_pc <= redirect_pc.
  - stale <= stale + live, plus any response arriving in cycle R that would have been live is dropped.
  - live <= 0.
  - No request is issued in cycle R.
  - Fetch from redirect_pc may begin in R+1 while stale responses are still draining.
- Back-to-back redirects: the last one wins. Each redirect folds live into stale.
- FSM, two states, used for assertion coverage and debug:
  - FETCH: stale == 0.
  - DRAIN: stale > 0.
  - FETCH→DRAIN on a redirect with live > 0.
  - DRAIN→FETCH when the last stale response is dropped.
- Counter widths: $clog2(DEPTH)+1 bits. No counter ever exceeds DEPTH.

Optional Feature:
- Macro IFETCH_BYPASS_EN.
- Defined: when count==0, the response is live, and no redirect occurs, the response is driven combinationally onto inst_valid/inst_data/inst_pc in the same cycle.
  - If inst_ready=1 that cycle, the instruction is consumed and never written to the queue.
  - Latency is 0 cycles.
- Undefined: all responses pass through the queue with 1-cycle latency. All outputs derive only from registers.

Test Plan:
- Reset behaviour: rst held 3 cycles, RESET_PC=0 → imem_req_valid=0 and inst_valid=0 throughout. First request has addr 0x00 in the cycle after rst falls.
- Streaming: memory ready=1 with 1-cycle latency, data=addr+0x100, decode always ready → inst_data sequence 0x100,0x101,0x102… with inst_pc 0,1,2…, one per cycle after the pipeline fills.
- Backpressure: inst_ready=0 → after 4 responses, count=4 and imem_req_valid=0. Release inst_ready → 4 queued entries drain in order, then fetch resumes at addr 4.
- Redirect with 2 in flight: redirect_pc=0x40 → the 2 old responses are dropped and inst_valid stays 0 until data for 0x40 arrives. First inst_pc=0x40.
- Wrap and reset: redirect_pc=0xFE → inst_pc 0xFE,0xFF,0x00. Assert rst mid-stream → queue empty and fetch_pc=RESET_PC next cycle.
- IFETCH_BYPASS_EN defined: empty queue, response for addr 5 with inst_ready=1 → inst_valid=1 and inst_pc=5 in the same cycle. Without the macro, the same stimulus gives inst_valid one cycle later.
